// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
// master drives bytes and observes writes; slave is the loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [63:0]           mem_data;
  logic                  mem_write;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_addr, mem_data, mem_write
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_addr, mem_data, mem_write
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: byte stream -> 32-bit LE words -> RAM at BASE_ADDR.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int                    ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h800,
  parameter int                    MAX_WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t      state, state_n;
  logic [15:0] length;
  logic [23:0] word;
  logic [1:0]  idx;
  logic        xfer;
  logic        restart;
  logic        last_word;
  logic [15:0] new_len;
  state_t      fin_state;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign fin_state = S_CSUM;
`else
  assign fin_state = S_DONE;
`endif

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign new_len   = {bus.byte_in, length[7:0]};
  assign last_word = (word_count + 16'd1) == length;
  assign restart   = start &
                     (state inside {S_IDLE, S_DONE, S_ERR});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    bus.byte_ready = 1'b0;
    bus.mem_write  = 1'b0;
    cpu_rst        = 1'b1;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_LEN0;
      end
      S_LEN0: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer) state_n = S_LEN1;
      end
      S_LEN1: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer) begin
          if (new_len == 16'd0)
            state_n = fin_state;
          else if (new_len > 16'(MAX_WORDS))
            state_n = S_ERR;
          else
            state_n = S_DATA;
        end
      end
      S_DATA: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer && idx == 2'd3) state_n = S_WRITE;
      end
      S_WRITE: begin
        bus.mem_write = 1'b1;
        busy          = 1'b1;
        state_n       = last_word ? fin_state : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        bus.byte_ready = 1'b1;
        busy           = 1'b1;
        if (xfer)
          state_n = (bus.byte_in == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (start) state_n = S_LEN0;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) state_n = S_LEN0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Address/data are captured with the 4th byte so WRITE needs no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      length       <= '0;
      word         <= '0;
      idx          <= '0;
      word_count   <= '0;
      bus.mem_addr <= BASE_ADDR;
      bus.mem_data <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (restart) begin
      length     <= '0;
      idx        <= '0;
      word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      if (state == S_LEN0 && xfer)
        length[7:0] <= bus.byte_in;
      if (state == S_LEN1 && xfer)
        length[15:8] <= bus.byte_in;
      if (state == S_DATA && xfer) begin
        idx <= idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        csum <= csum ^ bus.byte_in;
`endif
        unique case (idx)
          2'd0: word[7:0]   <= bus.byte_in;
          2'd1: word[15:8]  <= bus.byte_in;
          2'd2: word[23:16] <= bus.byte_in;
          default: begin
            bus.mem_addr <= BASE_ADDR +
                            ADDR_WIDTH'(word_count);
            bus.mem_data <= {32'b0, bus.byte_in, word};
          end
        endcase
      end
      if (state == S_WRITE)
        word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: random byte pacing,
// expected RAM writes derived from the image contents.
module tb_program_loader;

  localparam logic [11:0] BASE = 12'h800;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        cpu_rst, busy, done, error;
  logic [15:0] word_count;

  program_loader_if pif ();

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (pif),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img [0:255];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (pif.mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h, none expected",
                 pif.mem_addr, pif.mem_data);
      end else begin
        e = exp_q.pop_front();
        check("mem_addr", 64'(pif.mem_addr), 64'(e.addr));
        check("mem_data", pif.mem_data, e.data);
        check("ready_in_write", 64'(pif.byte_ready), 64'd0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit got;
    if (rnd)
      while ($urandom_range(0, 2) == 0) begin
        pif.byte_valid = 1'b0;
        @(posedge clk); #1;
      end
    pif.byte_in    = b;
    pif.byte_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (pif.byte_ready === 1'b1) begin
        @(posedge clk); #1;
        got = 1'b1;
      end
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL byte_timeout: got no ready expected ready within 200 cycles");
    end
    pif.byte_valid = 1'b0;
  endtask

  task automatic wait_status(input bit ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) break;
    end
    check("done", 64'(done), 64'(ok));
    check("error", 64'(error), 64'(!ok));
    check("cpu_rst", 64'(cpu_rst), 64'(!ok));
    check("busy_end", 64'(busy), 64'd0);
  endtask

  task automatic run_image(input logic [15:0] len, input bit rnd,
                           input bit poke, input logic [7:0] flip);
    logic [7:0] x;
    logic [7:0] b;
    bit         ok;
    int         nw;
    x = 8'h00;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    send_byte(len[7:0], rnd);
    send_byte(len[15:8], rnd);
    ok = (int'(len) <= MAXW);
    nw = ok ? int'(len) : 0;
    for (int i = 0; i < nw; i++) begin
      exp_q.push_back('{BASE + 12'(i), {32'b0, img[i]}});
      if (poke && i == 1) pulse_start();
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, rnd);
      end
      @(negedge clk);
      check("write_latency", 64'(pif.mem_write), 64'd1);
    end
`ifdef LOADER_CHECKSUM_EN
    if (ok) begin
      send_byte(x ^ flip, rnd);
      ok = (flip == 8'h00);
    end
`else
    if (flip != 8'h00) x = x ^ flip;
`endif
    wait_status(ok);
    check("word_count", 64'(word_count), 64'(nw));
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    pif.byte_in    = 8'h00;
    pif.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_ready", 64'(pif.byte_ready), 64'd0);
    check("rst_mem_write", 64'(pif.mem_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(pif.mem_addr), 64'(BASE));
    check("rst_data", pif.mem_data, 64'd0);
    check("rst_wcount", 64'(word_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    img[0] = 32'h91000000; img[1] = 32'h91400001;
    img[2] = 32'h91800008; img[3] = 32'h8b010003;
    img[4] = 32'haa0103e0; img[5] = 32'haa0303e1;
    img[6] = 32'hf1000442; img[7] = 32'h54ffff81;
    run_image(16'd8, 1'b0, 1'b0, 8'h00);
    run_image(16'd8, 1'b1, 1'b1, 8'h00);

    run_image(16'h0101, 1'b0, 1'b0, 8'h00);
    run_image(16'd8, 1'b0, 1'b0, 8'h00);
    run_image(16'd0, 1'b0, 1'b0, 8'h00);
`ifdef LOADER_CHECKSUM_EN
    run_image(16'd0, 1'b0, 1'b0, 8'h01);
    img[0] = 32'h44332211;
    run_image(16'd1, 1'b0, 1'b0, 8'h00);
    run_image(16'd1, 1'b0, 1'b0, 8'h01);
`endif

    // Abort after the 6th data byte of a 3-word image.
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    pulse_start();
    send_byte(8'd3, 1'b0);
    send_byte(8'd0, 1'b0);
    exp_q.push_back('{BASE, {32'b0, img[0]}});
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b0);
    @(negedge clk);
    check("abort_first_write", 64'(pif.mem_write), 64'd1);
    send_byte(img[1][7:0], 1'b0);
    send_byte(img[1][15:8], 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cpu_rst", 64'(cpu_rst), 64'd1);
    check("abort_wcount", 64'(word_count), 64'd0);
    check("abort_ready", 64'(pif.byte_ready), 64'd0);
    run_image(16'd3, 1'b0, 1'b0, 8'h00);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      run_image(16'(n), 1'b1, 1'b0, 8'h00);
    end

    for (int i = 0; i < MAXW; i++) img[i] = $urandom;
    run_image(16'(MAXW), 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
